bus_frame_rx: RTL and testbench

Parametrised bit-serial frame receiver. It deserialises the bus frame (START | CMD | ADDR | DATA | PARITY | STOP) from a single serial line sampled on a bit strobe, and checks parity and the stop delimiter. Good frames are queued in a small FIFO with a valid/ready output. It sits at every master/slave serial ingress and generalises the fixed 27-bit format to arbitrary ADDR/DATA widths, selectable parity sense and a queue depth.

---
 rtl/bus_pkg.sv | 29 ++
 rtl/bus_frame_fifo.sv | 66 ++++++
 rtl/bus_frame_rx.sv | 150 +++++++++++++++
 tb/tb_bus_frame_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and helpers for the serial bus frame receiver/transmitter.
package bus_pkg;

    localparam int unsigned CMD_W     = 2;
    localparam int unsigned PAR_MAX_W = 256;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_BCAST = 2'b11
    } cmd_e;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_e;

    // Full frame length: START + CMD(2) + ADDR + DATA + PARITY + STOP
    function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
        return addr_w + data_w + 5;
    endfunction

    // Callers zero-extend their field to PAR_MAX_W; zero padding leaves the parity unchanged
    function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] bits, input logic odd);
        return (^bits) ^ odd;
    endfunction

endpackage

// File: rtl/bus_frame_fifo.sv
// First-word fall-through queue with registered head/flags; shared by the bus RX and TX paths.
module bus_frame_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_valid,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] w_rd_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_pop;
    logic          w_push;

    // A push into a full queue is accepted only when the head leaves in the same cycle
    assign w_pop     = i_pop && (r_cnt != '0);
    assign w_push    = i_push && ((r_cnt != CW'(DEPTH)) || w_pop);
    assign w_rd_nxt  = w_pop ? r_rd + AW'(1) : r_rd;
    assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            o_dout  <= '0;
            o_valid <= 1'b0;
            o_full  <= 1'b0;
            o_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            r_rd    <= w_rd_nxt;
            r_cnt   <= w_cnt_nxt;
            o_valid <= (w_cnt_nxt != '0);
            o_full  <= (w_cnt_nxt == CW'(DEPTH));
            o_empty <= (w_cnt_nxt == '0);
            // Next head bypasses memory when it is the entry being written this cycle
            if (w_cnt_nxt != '0) begin
                o_dout <= (w_push && (r_wr == w_rd_nxt)) ? i_din : r_mem[w_rd_nxt];
            end
        end
    end

endmodule

// File: rtl/bus_frame_rx.sv
// Bit-serial bus frame receiver: deserialises, checks parity/stop, queues good frames.
// Optional inter-bit timeout is enabled by defining BUS_RX_TIMEOUT_EN.
module bus_frame_rx
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = 14,
    parameter int unsigned DATA_W         = 8,
    parameter bit          ODD_PARITY     = 1'b0,
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid,
    input  logic              serial_in,
    output logic              rx_valid,
    input  logic              rx_ready,
    output cmd_e              rx_cmd,
    output logic [ADDR_W-1:0] rx_addr,
    output logic [DATA_W-1:0] rx_data,
    output logic              err_parity,
    output logic              err_stop,
    output logic              err_overflow,
    output logic              err_timeout,
    output logic              busy
);

    localparam int unsigned FW_C     = frame_w(ADDR_W, DATA_W);
    localparam int unsigned SR_W     = FW_C - 1;
    localparam int unsigned CNT_W    = $clog2(FW_C);
    localparam int unsigned PAY_W    = CMD_W + ADDR_W + DATA_W;
    localparam int unsigned LAST_CNT = FW_C - 2;

    rx_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SR_W-1:0]  r_sr;

    logic [FW_C-1:0]  w_frame;
    logic [PAY_W-1:0] w_payload;
    logic [PAY_W-1:0] w_head;
    logic             w_last;
    logic             w_delim_ok;
    logic             w_par_ok;
    logic             w_good;
    logic             w_pop;
    logic             w_ovf;
    logic             w_full;
    logic             w_empty;
    logic             w_fifo_valid;
    logic             w_to_hit;

    // Shift register holds START..PARITY; the STOP bit is judged straight off the line
    assign w_frame    = {r_sr, serial_in};
    assign w_payload  = w_frame[FW_C-2 -: PAY_W];
    assign w_last     = (r_state == RX_SHIFT) && bit_valid && (r_cnt == CNT_W'(LAST_CNT));
    assign w_delim_ok = w_frame[FW_C-1] & w_frame[0];
    assign w_par_ok   = (w_frame[1] == calc_parity(PAR_MAX_W'(w_payload), ODD_PARITY));
    assign w_good     = w_last && w_delim_ok && w_par_ok;
    assign w_pop      = rx_ready && !w_empty;
    assign w_ovf      = w_good && w_full && !w_pop;

`ifdef BUS_RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_idle_cnt;

    assign w_to_hit = (r_state == RX_SHIFT) && !bit_valid
                   && (r_idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Clock cycles since the last strobe while a frame is in flight
    always_ff @(posedge clk) begin
        if (rst || (r_state != RX_SHIFT) || bit_valid) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + TO_W'(1);
        end
    end
`else
    assign w_to_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RX_IDLE;
            r_cnt        <= '0;
            r_sr         <= '0;
            busy         <= 1'b0;
            err_parity   <= 1'b0;
            err_stop     <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_stop     <= w_last && !w_delim_ok;
            err_parity   <= w_last && w_delim_ok && !w_par_ok;
            err_overflow <= w_ovf;
            err_timeout  <= w_to_hit;
            case (r_state)
                RX_IDLE: begin
                    if (bit_valid && serial_in) begin
                        r_state <= RX_SHIFT;
                        r_cnt   <= '0;
                        r_sr    <= SR_W'(1);
                        busy    <= 1'b1;
                    end
                end
                RX_SHIFT: begin
                    if (bit_valid) begin
                        r_sr <= w_frame[SR_W-1:0];
                        if (w_last) begin
                            r_state <= RX_IDLE;
                            r_cnt   <= '0;
                            busy    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (w_to_hit) begin
                        r_state <= RX_IDLE;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RX_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    bus_frame_fifo #(
        .W     (PAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_good && !w_ovf),
        .i_din   (w_payload),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_valid (w_fifo_valid),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rx_valid = w_fifo_valid;
    assign rx_cmd   = cmd_e'(w_head[PAY_W-1 -: CMD_W]);
    assign rx_addr  = w_head[DATA_W +: ADDR_W];
    assign rx_data  = w_head[DATA_W-1:0];

endmodule

// File: tb/tb_bus_frame_rx.sv
// Self-checking bench for bus_frame_rx: frame-level model for the default instance plus directed literals.
module tb_bus_frame_rx;

    localparam int FW1 = 27;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, bv, si, rdy, bv2, si2, rdy2;
    logic        rx_valid, ep, es, eo, et, busy;
    logic [1:0]  rx_cmd;
    logic [13:0] rx_addr;
    logic [7:0]  rx_data;
    logic        rx2_valid, ep2, es2, eo2, et2, busy2;
    logic [1:0]  rx2_cmd;
    logic [9:0]  rx2_addr;
    logic [15:0] rx2_data;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    bus_frame_rx dut (
        .clk(clk), .rst(rst), .bit_valid(bv), .serial_in(si),
        .rx_valid(rx_valid), .rx_ready(rdy), .rx_cmd(rx_cmd), .rx_addr(rx_addr), .rx_data(rx_data),
        .err_parity(ep), .err_stop(es), .err_overflow(eo), .err_timeout(et), .busy(busy)
    );

    bus_frame_rx #(.ADDR_W(10), .DATA_W(16), .ODD_PARITY(1'b1)) dut2 (
        .clk(clk), .rst(rst), .bit_valid(bv2), .serial_in(si2),
        .rx_valid(rx2_valid), .rx_ready(rdy2), .rx_cmd(rx2_cmd), .rx_addr(rx2_addr), .rx_data(rx2_data),
        .err_parity(ep2), .err_stop(es2), .err_overflow(eo2), .err_timeout(et2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Good-parity (even) frame for the default instance; pflip=1 corrupts the parity bit
    function automatic logic [26:0] mk1(input logic [1:0] c, input logic [13:0] a,
                                        input logic [7:0] d, input logic pflip, input logic stop);
        return {1'b1, c, a, d, (^{c, a, d}) ^ pflip, stop};
    endfunction

    task automatic send(input bit sel, input logic [63:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            if (sel) begin bv2 = 1'b1; si2 = bits[i]; end
            else     begin bv  = 1'b1; si  = bits[i]; end
            @(posedge clk); #1;
            bv = 1'b0; si = 1'b0; bv2 = 1'b0; si2 = 1'b0;
            if (i != 0) repeat (gap - 1) begin @(posedge clk); #1; end
        end
    endtask

    // Frame-level model of the default instance
    typedef struct packed {
        logic [1:0]  cmd;
        logic [13:0] addr;
        logic [7:0]  data;
    } frm_t;

    frm_t        m_q[$];
    bit          m_active = 1'b0;
    int          m_n = 0;
    int          m_idle = 0;
    logic [63:0] m_bits = '0;
    logic        x_valid = 1'b0, x_par = 1'b0, x_stop = 1'b0, x_ovf = 1'b0, x_to = 1'b0, x_busy = 1'b0;
    frm_t        x_head = '0;

    always @(posedge clk) begin
        frm_t f;
        bit   pop, push;
        logic exp_p;
        f = '0;
        push = 1'b0;
        x_par = 1'b0; x_stop = 1'b0; x_ovf = 1'b0; x_to = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_idle = 0;
            m_q.delete();
        end else begin
            pop = rdy && (m_q.size() != 0);
            if (bv) begin
                m_idle = 0;
                if (!m_active) begin
                    if (si) begin m_active = 1'b1; m_n = 0; m_bits = '0; end
                end else begin
                    m_bits = (m_bits << 1) | 64'(si);
                    m_n++;
                    if (m_n == FW1 - 1) begin
                        m_active = 1'b0;
                        f.data = 8'(m_bits >> 2);
                        f.addr = 14'(m_bits >> 10);
                        f.cmd  = 2'(m_bits >> 24);
                        exp_p  = (($countones({f.cmd, f.addr, f.data}) % 2) == 1);
                        if (m_bits[0] == 1'b0)          x_stop = 1'b1;
                        else if (m_bits[1] != exp_p)    x_par  = 1'b1;
                        else if (m_q.size() == 2 && !pop) x_ovf = 1'b1;
                        else                            push   = 1'b1;
                    end
                end
            end else if (m_active) begin
                m_idle++;
`ifdef BUS_RX_TIMEOUT_EN
                if (m_idle == 64) begin m_active = 1'b0; x_to = 1'b1; end
`endif
            end
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(f);
        end
        x_valid = (m_q.size() != 0);
        if (x_valid) x_head = m_q[0];
        x_busy = m_active;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", rx_valid, x_valid);
            chk("err_parity", ep, x_par);
            chk("err_stop", es, x_stop);
            chk("err_overflow", eo, x_ovf);
            chk("err_timeout", et, x_to);
            chk("busy", busy, x_busy);
            if (x_valid) begin
                chk("cmd", rx_cmd, x_head.cmd);
                chk("addr", rx_addr, x_head.addr);
                chk("data", rx_data, x_head.data);
            end
        end
    end

    initial begin
        rst = 1'b1; bv = 1'b0; si = 1'b0; rdy = 1'b1; bv2 = 1'b0; si2 = 1'b0; rdy2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", rx_addr, 0);
        chk("rst_errs", {ep, es, eo, et}, 0);
        chk("rst_valid2", rx2_valid, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Good frame, hand-computed parity 1
        send(1'b0, 64'({1'b1, 2'b01, 14'h0123, 8'hA5, 1'b1, 1'b1}), 27, 4);
        chk("t1_valid", rx_valid, 1);
        chk("t1_cmd", rx_cmd, 2'b01);
        chk("t1_addr", rx_addr, 14'h0123);
        chk("t1_data", rx_data, 8'hA5);
        chk("t1_errs", {ep, es, eo}, 0);
        chk("t1_busy", busy, 0);
        @(posedge clk); #1;
        chk("t1_popped", rx_valid, 0);

        // Parity error, then stop error with parity also wrong
        send(1'b0, 64'({1'b1, 2'b01, 14'h0123, 8'hA5, 1'b0, 1'b1}), 27, 4);
        chk("t2_par", ep, 1);
        chk("t2_valid", rx_valid, 0);
        @(posedge clk); #1;
        chk("t2_par_pulse", ep, 0);
        send(1'b0, 64'({1'b1, 2'b01, 14'h0123, 8'hA5, 1'b0, 1'b0}), 27, 4);
        chk("t3_stop", es, 1);
        chk("t3_par", ep, 0);
        @(posedge clk); #1;

        // Overflow: three back-to-back frames into a stalled 2-deep queue
        rdy = 1'b0;
        send(1'b0, 64'(mk1(2'b10, 14'h0001, 8'h11, 1'b0, 1'b1)), 27, 2);
        send(1'b0, 64'(mk1(2'b10, 14'h0002, 8'h22, 1'b0, 1'b1)), 27, 2);
        send(1'b0, 64'(mk1(2'b10, 14'h0003, 8'h33, 1'b0, 1'b1)), 27, 2);
        chk("t4_ovf", eo, 1);
        chk("t4_head1", rx_data, 8'h11);
        rdy = 1'b1;
        @(posedge clk); #1;
        chk("t4_head2", rx_data, 8'h22);
        @(posedge clk); #1;
        chk("t4_empty", rx_valid, 0);

        // Full queue, STOP of third frame coincides with a pop
        rdy = 1'b0;
        send(1'b0, 64'(mk1(2'b01, 14'h0004, 8'h44, 1'b0, 1'b1)), 27, 2);
        send(1'b0, 64'(mk1(2'b01, 14'h0005, 8'h55, 1'b0, 1'b1)), 27, 2);
        send(1'b0, 64'(mk1(2'b01, 14'h0006, 8'h66, 1'b0, 1'b1) >> 1), 26, 2);
        rdy = 1'b1; bv = 1'b1; si = 1'b1;
        @(posedge clk); #1;
        bv = 1'b0; si = 1'b0;
        chk("t5_no_ovf", eo, 0);
        chk("t5_head2", rx_data, 8'h55);
        @(posedge clk); #1;
        chk("t5_head3", rx_data, 8'h66);
        @(posedge clk); #1;
        chk("t5_empty", rx_valid, 0);

        // Zeros on the idle line
        send(1'b0, 64'h0, 5, 3);
        @(posedge clk); #1;
        chk("t6_busy", busy, 0);
        chk("t6_valid", rx_valid, 0);

        // Wide, odd-parity instance with leading idle zeros
        send(1'b1, 64'({5'b00000, 1'b1, 2'b11, 10'h3FF, 16'hBEEF, 1'b0, 1'b1}), 36, 3);
        chk("t7_valid2", rx2_valid, 1);
        chk("t7_cmd2", rx2_cmd, 2'b11);
        chk("t7_addr2", rx2_addr, 10'h3FF);
        chk("t7_data2", rx2_data, 16'hBEEF);
        chk("t7_errs2", {ep2, es2, eo2, et2, busy2}, 0);
        @(posedge clk); #1;
        chk("t7_popped2", rx2_valid, 0);
        send(1'b1, 64'({1'b1, 2'b11, 10'h3FF, 16'hBEEF, 1'b1, 1'b1}), 31, 3);
        chk("t7_par2", ep2, 1);
        chk("t7_nofrm2", rx2_valid, 0);

        // Reset in the middle of a frame
        send(1'b0, 64'(mk1(2'b11, 14'h2AAA, 8'h5A, 1'b0, 1'b1) >> 17), 10, 2);
        chk("t8_busy_mid", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t8_busy", busy, 0);
        chk("t8_errs", {ep, es, eo, et}, 0);
        chk("t8_valid", rx_valid, 0);
        repeat (3) begin @(posedge clk); #1; end
        send(1'b0, 64'(mk1(2'b11, 14'h3FFF, 8'h77, 1'b0, 1'b1)), 27, 3);
        chk("t8_valid_after", rx_valid, 1);
        chk("t8_data_after", rx_data, 8'h77);
        chk("t8_addr_after", rx_addr, 14'h3FFF);

`ifdef BUS_RX_TIMEOUT_EN
        // Strobes stop after five payload bits
        send(1'b0, 64'(mk1(2'b01, 14'h1234, 8'h9C, 1'b0, 1'b1) >> 21), 6, 4);
        repeat (63) begin @(posedge clk); #1; end
        chk("t9_no_to_yet", et, 0);
        chk("t9_busy", busy, 1);
        @(posedge clk); #1;
        chk("t9_timeout", et, 1);
        chk("t9_idle", busy, 0);
        send(1'b0, 64'(mk1(2'b01, 14'h1234, 8'h9C, 1'b0, 1'b1)), 27, 4);
        chk("t9_valid_after", rx_valid, 1);
        chk("t9_data_after", rx_data, 8'h9C);
`endif

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
